// File: rtl/qdrc_pkg.sv
// qdrc_pkg: shared state encoding, counter widths and calibration pattern helper
// for the QDR PHY calibration sequencer.
package qdrc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DLYRST,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_CHECK,
        ST_ADJUST,
        ST_DONE,
        ST_FAIL
    } qdrc_state_t;

    localparam int         TAP_W    = 6;
    localparam int         CNT_W    = 6;
    localparam logic [1:0] LAST_IDX = 2'd3;

    // Expected bit of pattern idx on one edge; odd selects the A/5 phase.
    function automatic logic pat_bit(input logic [1:0] idx, input logic fall, input logic odd);
        case (idx)
            2'd0:    return ~fall;
            2'd1:    return fall;
            2'd2:    return odd ^ fall;
            default: return ~(odd ^ fall);
        endcase
    endfunction

endpackage

// File: rtl/qdrc_phy_seq_cmp.sv
// qdrc_phy_seq_cmp: tracks issued calibration reads through the read latency and
// accumulates a sticky per-bit error against the expected pattern.
module qdrc_phy_seq_cmp
    import qdrc_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int RD_LATENCY = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  rd_issue,
    input  logic [1:0]            rd_idx,
    input  logic [DATA_WIDTH-1:0] q_rise,
    input  logic [DATA_WIDTH-1:0] q_fall,
    output logic [DATA_WIDTH-1:0] err
);

    logic            vld  [RD_LATENCY+1];
    logic [1:0]      pidx [RD_LATENCY+1];
    logic [DATA_WIDTH-1:0] exp_rise;
    logic [DATA_WIDTH-1:0] exp_fall;

    always_comb begin
        exp_rise = '0;
        exp_fall = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            exp_rise[i] = pat_bit(pidx[RD_LATENCY], 1'b0, (i % 2) == 1);
            exp_fall[i] = pat_bit(pidx[RD_LATENCY], 1'b1, (i % 2) == 1);
        end
    end

    // Stage 0 lines up with the registered qdr_r_n, so stage RD_LATENCY meets the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                vld[i]  <= 1'b0;
                pidx[i] <= 2'd0;
            end
            err <= '0;
        end else begin
            vld[0]  <= rd_issue;
            pidx[0] <= rd_idx;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                vld[i]  <= vld[i-1];
                pidx[i] <= pidx[i-1];
            end
            if (clear)
                err <= '0;
            else if (vld[RD_LATENCY])
                err <= err | (q_rise ^ exp_rise) | (q_fall ^ exp_fall);
        end
    end

endmodule

// File: rtl/qdrc_phy_seq.sv
// qdrc_phy_seq: QDR PHY front end with a self-contained write/read-back IDELAY calibration sequencer.
// Optional build macro QDRC_PHY_SEQ_DLYRST_EN: reset all taps to zero at the start of each calibration.
//
// state   | meaning
// IDLE    | waiting for cal_start, user path blocked
// DLYRST  | dly_rst pulse plus two settle cycles
// WRITE   | write P0..P3 to addresses 0..3
// READ    | read addresses 0..3
// WAIT    | drain read latency into the comparator
// CHECK   | merge errors into pass mask, decide
// ADJUST  | step every unlocked bit by one tap
// DONE    | calibrated, user path live
// FAIL    | tap budget exhausted
module qdrc_phy_seq
    import qdrc_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 21,
    parameter int RD_LATENCY = 10,
    parameter int MAX_TAPS   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cal_start,
    output logic                    phy_rdy,
    output logic                    cal_fail,
    output logic                    cal_busy,
    output logic [DATA_WIDTH-1:0]   cal_pass_mask,
    output logic [TAP_W-1:0]        cal_tap_cnt,
    input  logic                    phy_wr_strb,
    input  logic                    phy_rd_strb,
    input  logic [ADDR_WIDTH-1:0]   phy_addr,
    input  logic [2*DATA_WIDTH-1:0] phy_wr_data,
    output logic [2*DATA_WIDTH-1:0] phy_rd_data,
    output logic [DATA_WIDTH-1:0]   qdr_d_rise,
    output logic [DATA_WIDTH-1:0]   qdr_d_fall,
    input  logic [DATA_WIDTH-1:0]   qdr_q_rise,
    input  logic [DATA_WIDTH-1:0]   qdr_q_fall,
    output logic [ADDR_WIDTH-1:0]   qdr_sa,
    output logic                    qdr_w_n,
    output logic                    qdr_r_n,
    output logic [DATA_WIDTH-1:0]   dly_inc_dec_n,
    output logic [DATA_WIDTH-1:0]   dly_en,
    output logic [DATA_WIDTH-1:0]   dly_rst
);

    qdrc_state_t           state;
    logic [1:0]            idx;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] err;
    logic [DATA_WIDTH-1:0] pass_next;
    logic [DATA_WIDTH-1:0] seq_rise;
    logic [DATA_WIDTH-1:0] seq_fall;
    logic                  can_start;
    logic                  cmp_clear;

    assign can_start = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL);
    assign cmp_clear = (state == ST_ADJUST) || (cal_start && can_start);
    assign pass_next = cal_pass_mask | ~err;

    always_comb begin
        seq_rise = '0;
        seq_fall = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            seq_rise[i] = pat_bit(idx, 1'b0, (i % 2) == 1);
            seq_fall[i] = pat_bit(idx, 1'b1, (i % 2) == 1);
        end
    end

    qdrc_phy_seq_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .RD_LATENCY(RD_LATENCY)
    ) u_cmp (
        .clk     (clk),
        .reset   (reset),
        .clear   (cmp_clear),
        .rd_issue(state == ST_READ),
        .rd_idx  (idx),
        .q_rise  (qdr_q_rise),
        .q_fall  (qdr_q_fall),
        .err     (err)
    );

    always_ff @(posedge clk) begin
        if (reset)
            phy_rd_data <= '0;
        else
            phy_rd_data <= {qdr_q_fall, qdr_q_rise};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= 2'd0;
            cnt           <= '0;
            phy_rdy       <= 1'b0;
            cal_fail      <= 1'b0;
            cal_busy      <= 1'b0;
            cal_pass_mask <= '0;
            cal_tap_cnt   <= '0;
            qdr_w_n       <= 1'b1;
            qdr_r_n       <= 1'b1;
            qdr_sa        <= '0;
            qdr_d_rise    <= '0;
            qdr_d_fall    <= '0;
            dly_inc_dec_n <= '0;
            dly_en        <= '0;
            dly_rst       <= '0;
        end else begin
            qdr_w_n       <= 1'b1;
            qdr_r_n       <= 1'b1;
            qdr_sa        <= '0;
            qdr_d_rise    <= '0;
            qdr_d_fall    <= '0;
            dly_inc_dec_n <= '0;
            dly_en        <= '0;
            dly_rst       <= '0;
            if (phy_rdy) begin
                qdr_w_n    <= ~phy_wr_strb;
                qdr_r_n    <= ~phy_rd_strb;
                qdr_sa     <= phy_addr;
                qdr_d_rise <= phy_wr_data[DATA_WIDTH-1:0];
                qdr_d_fall <= phy_wr_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (cal_start) begin
                        cal_pass_mask <= '0;
                        cal_tap_cnt   <= '0;
                        cal_fail      <= 1'b0;
                        phy_rdy       <= 1'b0;
                        cal_busy      <= 1'b1;
                        idx           <= 2'd0;
`ifdef QDRC_PHY_SEQ_DLYRST_EN
                        state         <= ST_DLYRST;
                        cnt           <= CNT_W'(2);
`else
                        state         <= ST_WRITE;
`endif
                    end
                end
`ifdef QDRC_PHY_SEQ_DLYRST_EN
                ST_DLYRST: begin
                    if (cnt == CNT_W'(2))
                        dly_rst <= '1;
                    if (cnt == '0)
                        state <= ST_WRITE;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
`endif
                ST_WRITE: begin
                    qdr_w_n    <= 1'b0;
                    qdr_sa     <= ADDR_WIDTH'(idx);
                    qdr_d_rise <= seq_rise;
                    qdr_d_fall <= seq_fall;
                    idx        <= idx + 2'd1;
                    if (idx == LAST_IDX)
                        state <= ST_READ;
                end
                ST_READ: begin
                    qdr_r_n <= 1'b0;
                    qdr_sa  <= ADDR_WIDTH'(idx);
                    idx     <= idx + 2'd1;
                    if (idx == LAST_IDX) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_W'(RD_LATENCY + 3);
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0)
                        state <= ST_CHECK;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                ST_CHECK: begin
                    cal_pass_mask <= pass_next;
                    if (&pass_next) begin
                        state    <= ST_DONE;
                        phy_rdy  <= 1'b1;
                        cal_busy <= 1'b0;
                    end else if (cal_tap_cnt == TAP_W'(MAX_TAPS)) begin
                        state    <= ST_FAIL;
                        cal_fail <= 1'b1;
                        cal_busy <= 1'b0;
                    end else begin
                        state <= ST_ADJUST;
                    end
                end
                ST_ADJUST: begin
                    dly_en        <= ~cal_pass_mask;
                    dly_inc_dec_n <= '1;
                    cal_tap_cnt   <= cal_tap_cnt + TAP_W'(1);
                    idx           <= 2'd0;
                    state         <= ST_READ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qdrc_phy_seq.sv
// tb_qdrc_phy_seq: directed and randomised checks of qdrc_phy_seq against a QDR/IDELAY
// behavioural model with per-bit tap-dependent faults.
module tb_qdrc_phy_seq;

    localparam int DW = 36;
    localparam int AW = 21;
    localparam int RL = 10;
    localparam int MT = 4;
`ifdef QDRC_PHY_SEQ_DLYRST_EN
    localparam int DLY_EXTRA = 3;
`else
    localparam int DLY_EXTRA = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            cal_start;
    logic            phy_rdy, cal_fail, cal_busy;
    logic [DW-1:0]   cal_pass_mask;
    logic [5:0]      cal_tap_cnt;
    logic            phy_wr_strb, phy_rd_strb;
    logic [AW-1:0]   phy_addr;
    logic [2*DW-1:0] phy_wr_data, phy_rd_data;
    logic [DW-1:0]   qdr_d_rise, qdr_d_fall, qdr_q_rise, qdr_q_fall;
    logic [AW-1:0]   qdr_sa;
    logic            qdr_w_n, qdr_r_n;
    logic [DW-1:0]   dly_inc_dec_n, dly_en, dly_rst;

    qdrc_phy_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL), .MAX_TAPS(MT)) dut (
        .clk(clk), .reset(reset), .cal_start(cal_start), .phy_rdy(phy_rdy), .cal_fail(cal_fail),
        .cal_busy(cal_busy), .cal_pass_mask(cal_pass_mask), .cal_tap_cnt(cal_tap_cnt),
        .phy_wr_strb(phy_wr_strb), .phy_rd_strb(phy_rd_strb), .phy_addr(phy_addr),
        .phy_wr_data(phy_wr_data), .phy_rd_data(phy_rd_data), .qdr_d_rise(qdr_d_rise),
        .qdr_d_fall(qdr_d_fall), .qdr_q_rise(qdr_q_rise), .qdr_q_fall(qdr_q_fall), .qdr_sa(qdr_sa),
        .qdr_w_n(qdr_w_n), .qdr_r_n(qdr_r_n), .dly_inc_dec_n(dly_inc_dec_n), .dly_en(dly_en),
        .dly_rst(dly_rst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // IO model: ideal QDR memory plus per-bit IDELAY taps; need[i] < 0 means stuck at 1.
    int          need [DW];
    int          tap [DW];
    int          en_pulses [DW];
    int          incdec_bad = 0;
    int          clear_req = 0, clear_seen = 0;
    logic [71:0] mem [logic [AW-1:0]];
    logic        sched_v [64];
    logic [71:0] sched_d [64];
    logic [71:0] io_d;
    logic [71:0] last_q = '0;

    initial for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;

    always @(negedge clk) begin
        if (clear_req != clear_seen) begin
            clear_seen = clear_req;
            for (int i = 0; i < DW; i++) begin
                tap[i] = 0;
                en_pulses[i] = 0;
            end
        end
        if (dly_en != '0 && dly_inc_dec_n != '1) incdec_bad++;
        for (int i = 0; i < DW; i++) begin
            if (dly_rst[i]) tap[i] = 0;
            else if (dly_en[i]) begin
                tap[i]++;
                en_pulses[i]++;
            end
        end
        if (!qdr_w_n) mem[qdr_sa] = {qdr_d_fall, qdr_d_rise};
        if (!qdr_r_n) begin
            sched_v[(cyc + RL) % 64] = 1'b1;
            sched_d[(cyc + RL) % 64] = mem.exists(qdr_sa) ? mem[qdr_sa] : '0;
        end
        if (sched_v[cyc % 64]) begin
            sched_v[cyc % 64] = 1'b0;
            io_d = sched_d[cyc % 64];
            for (int i = 0; i < DW; i++) begin
                if (need[i] < 0) begin
                    io_d[i] = 1'b1;
                    io_d[DW+i] = 1'b1;
                end else if (tap[i] < need[i]) begin
                    io_d[i] = ~io_d[i];
                    io_d[DW+i] = ~io_d[DW+i];
                end
            end
        end else begin
            io_d = {8'd0, $urandom, $urandom};
            io_d[71:64] = 8'($urandom);
        end
        qdr_q_rise = io_d[DW-1:0];
        qdr_q_fall = io_d[2*DW-1:DW];
        last_q = {qdr_q_fall, qdr_q_rise};
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " phy_rdy"}, 128'(phy_rdy), 128'(0));
        chk({tag, " cal_fail"}, 128'(cal_fail), 128'(0));
        chk({tag, " cal_busy"}, 128'(cal_busy), 128'(0));
        chk({tag, " pass_mask"}, 128'(cal_pass_mask), 128'(0));
        chk({tag, " tap_cnt"}, 128'(cal_tap_cnt), 128'(0));
        chk({tag, " w_n/r_n"}, 128'({qdr_w_n, qdr_r_n}), 128'(2'b11));
        chk({tag, " sa"}, 128'(qdr_sa), 128'(0));
        chk({tag, " d"}, 128'({qdr_d_fall, qdr_d_rise}), 128'(0));
        chk({tag, " dly"}, 128'({dly_inc_dec_n, dly_en, dly_rst}), 128'(0));
        chk({tag, " rd_data"}, 128'(phy_rd_data), 128'(0));
    endtask

    // Outcome derived from need[]: each bit locks at the first check after need[i] taps.
    task automatic run_cal(input string tag, input bit poke);
        int m = 0, total, exp_lat, n = 0, rst_bad = 0, pulse_bad = 0, ep;
        bit ok = 1'b1;
        logic [DW-1:0] exp_mask = '0;
        for (int i = 0; i < DW; i++) begin
            if (need[i] < 0 || need[i] > MT) ok = 1'b0;
            else begin
                exp_mask[i] = 1'b1;
                if (need[i] > m) m = need[i];
            end
        end
        total = ok ? m : MT;
        exp_lat = DLY_EXTRA + 1 + 4 + 4 + (RL + 4) + 1 + total * (1 + 4 + (RL + 4) + 1);
        clear_req++;
        cal_start = 1'b1;
        while (n < 2000) begin
            step();
            n++;
            if (n == 1) begin
                cal_start = 1'b0;
                chk({tag, " busy"}, 128'(cal_busy), 128'(1));
            end
            if (poke) cal_start = (n == 5);
`ifdef QDRC_PHY_SEQ_DLYRST_EN
            if (dly_rst !== ((n == 1) ? {DW{1'b1}} : {DW{1'b0}})) rst_bad++;
`else
            if (dly_rst !== '0) rst_bad++;
`endif
            if (phy_rdy || cal_fail) break;
        end
        cal_start = 1'b0;
        for (int i = 0; i < DW; i++) begin
            ep = (need[i] < 0 || need[i] > total) ? total : need[i];
            if (en_pulses[i] != ep) pulse_bad++;
        end
        chk({tag, " latency"}, 128'(n), 128'(exp_lat));
        chk({tag, " phy_rdy"}, 128'(phy_rdy), 128'(ok));
        chk({tag, " cal_fail"}, 128'(cal_fail), 128'(!ok));
        chk({tag, " pass_mask"}, 128'(cal_pass_mask), 128'(exp_mask));
        chk({tag, " tap_cnt"}, 128'(cal_tap_cnt), 128'(total));
        chk({tag, " busy_end"}, 128'(cal_busy), 128'(0));
        chk({tag, " dly_en pulses"}, 128'(pulse_bad), 128'(0));
        chk({tag, " dly_rst"}, 128'(rst_bad), 128'(0));
    endtask

    task automatic strobes_ignored(input string tag);
        phy_wr_strb = 1'b1;
        phy_rd_strb = 1'b1;
        phy_addr = AW'(5);
        step();
        chk({tag, " w_n/r_n"}, 128'({qdr_w_n, qdr_r_n}), 128'(2'b11));
        phy_wr_strb = 1'b0;
        phy_rd_strb = 1'b0;
    endtask

    typedef struct { int due; logic [71:0] d; } rd_t;
    rd_t rq[$];
    logic [71:0] umem [logic [AW-1:0]];

    initial begin
        bit pw, pr;
        logic [AW-1:0] pa;
        logic [71:0] pd;
        reset = 1'b1;
        cal_start = 1'b0;
        phy_wr_strb = 1'b0;
        phy_rd_strb = 1'b0;
        phy_addr = '0;
        phy_wr_data = '0;
        for (int i = 0; i < DW; i++) need[i] = 0;
        repeat (3) step();
        check_reset_vals("reset");
        reset = 1'b0;
        step();
        strobes_ignored("idle_strobe");

        run_cal("ideal", 1'b1);

        // User write and read on the same cycle.
        phy_wr_strb = 1'b1;
        phy_rd_strb = 1'b1;
        phy_addr = AW'(21'h1234);
        phy_wr_data = {36'hA_AAAA_AAAA, 36'hB_BBBB_BBBB};
        step();
        phy_wr_strb = 1'b0;
        phy_rd_strb = 1'b0;
        chk("user w_n/r_n", 128'({qdr_w_n, qdr_r_n}), 128'(2'b00));
        chk("user sa", 128'(qdr_sa), 128'(21'h1234));
        chk("user d_rise", 128'(qdr_d_rise), 128'(36'hB_BBBB_BBBB));
        chk("user d_fall", 128'(qdr_d_fall), 128'(36'hA_AAAA_AAAA));
        step();

        // Random user traffic with end-to-end read data tracking.
        for (int k = 0; k < 80; k++) begin
            pw = (k < 60) && ($urandom_range(0, 1) == 1);
            pr = (k < 60) && ($urandom_range(0, 1) == 1);
            pa = AW'(16 + $urandom_range(0, 7));
            pd = {8'd0, $urandom, $urandom};
            pd[71:64] = 8'($urandom);
            phy_wr_strb = pw;
            phy_rd_strb = pr;
            phy_addr = pa;
            phy_wr_data = pd;
            if (pw) umem[pa] = pd;
            if (pr) rq.push_back('{cyc + RL + 2, umem.exists(pa) ? umem[pa] : 72'd0});
            step();
            if (k < 60) begin
                chk("rand w_n/r_n", 128'({qdr_w_n, qdr_r_n}), 128'({!pw, !pr}));
                if (pw | pr) chk("rand sa", 128'(qdr_sa), 128'(pa));
                if (pw) chk("rand d", 128'({qdr_d_fall, qdr_d_rise}), 128'(pd));
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("rand rd_data", 128'(phy_rd_data), 128'(rq[0].d));
                void'(rq.pop_front());
            end
        end
        phy_wr_strb = 1'b0;
        phy_rd_strb = 1'b0;
        chk("rand rd drained", 128'(rq.size()), 128'(0));
        chk("rd_data reg", 128'(phy_rd_data), 128'(last_q));

        need[5] = 3;
        run_cal("skew5", 1'b0);

        for (int i = 0; i < DW; i++) need[i] = 0;
        for (int j = 0; j < 3; j++) need[$urandom_range(0, DW-1)] = $urandom_range(0, MT + 1);
        run_cal("rand_skew", 1'b0);

        for (int i = 0; i < DW; i++) need[i] = 0;
        need[0] = -1;
        run_cal("stuck0", 1'b0);
        strobes_ignored("fail_strobe");

        // Reset in the middle of WAIT.
        for (int i = 0; i < DW; i++) need[i] = 0;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        repeat (11) step();
        reset = 1'b1;
        step();
        check_reset_vals("reset_wait");
        reset = 1'b0;
        step();
        run_cal("after_reset", 1'b0);

        chk("inc_dec_n with en", 128'(incdec_bad), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
